// File: rtl/dmem_ctrl.sv
// Data memory controller: byte/half/word access to a 32-bit word array behind a
// req/ack handshake with WAIT_CYC wait states and misalignment rejection.
module dmem_ctrl #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              misalign
);
    localparam int unsigned DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC);

    if (DATA_W != 32 || WAIT_CYC > 15 || ADDR_W < 3) begin : g_bad_param
        $error("dmem_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];

    logic              is_misaligned;
    logic              access;
    logic              mem_wr;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;
    logic [3:0]        st_be;
    logic [31:0]       st_lanes;

    always_comb begin
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr[0];
            2'b10:   is_misaligned = |addr[1:0];
            default: is_misaligned = 1'b1;
        endcase
    end

    assign access   = (state_q == StBusy) && (cnt_q == WAIT_LAST);
    // Gated by rst_n so a reset on the access edge never lands a store.
    assign mem_wr   = access && we_q && rst_n;
    assign word_idx = addr_q[ADDR_W-1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = rd_word;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[word_idx][8*b +: 8] <= st_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            ack      <= 1'b0;
            misalign <= 1'b0;
            case (state_q)
                StBusy: begin
                    if (access) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        ack     <= 1'b1;
                        rdata   <= we_q ? '0 : ld_val;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= unsigned_ld;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= '0;
                        if (is_misaligned) begin
                            state_q  <= StDone;
                            ack      <= 1'b1;
                            misalign <= 1'b1;
                            rdata    <= '0;
                        end else begin
                            state_q <= StBusy;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (WAIT_CYC 1, 0, 3), directed scenarios plus
// random accesses against a byte-array reference model.
module tb_dmem_ctrl;
    logic             clk = 1'b0;
    logic [2:0]       rst_n;
    logic [2:0]       req, we, unsigned_ld;
    logic [2:0][1:0]  size;
    logic [2:0][11:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;
    logic [2:0]       ack, busy, misalign;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_ctrl #(
            .ADDR_W   (12),
            .WAIT_CYC (g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .DATA_W   (32)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .req         (req[g]),
            .we          (we[g]),
            .size        (size[g]),
            .unsigned_ld (unsigned_ld[g]),
            .addr        (addr[g]),
            .wdata       (wdata[g]),
            .rdata       (rdata[g]),
            .ack         (ack[g]),
            .busy        (busy[g]),
            .misalign    (misalign[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_mis(input logic [1:0] sz, input logic [11:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz,
                                             input logic u);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++) ref_mem[int'(a) + k] = 8'(wd >> (8 * k));
    endtask

    // One access; lat = edges after the accepting edge until ack is seen, -1 on timeout.
    task automatic access(input int i, input logic w, input logic [1:0] sz, input logic u,
                          input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output int lat,
                          output int bcnt);
        int edges;
        bit got;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; size[i] = sz; unsigned_ld[i] = u;
        addr[i] = a; wdata[i] = wd;
        edges = 0; bcnt = 0; got = 1'b0; lat = -1; rd = 32'hxxxx_xxxx; mis = 1'bx;
        while (!got && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            req[i] = 1'b0;
            edges++;
            if (busy[i]) bcnt++;
            if (ack[i]) begin
                got = 1'b1; lat = edges - 1; rd = rdata[i]; mis = misalign[i];
            end
        end
    endtask

    task automatic load_chk(input int i, input string tag, input logic [1:0] sz, input logic u,
                            input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic mis; int lat, bc;
        access(i, 1'b0, sz, u, a, 32'h0, rd, mis, lat, bc);
        chk(tag, rd, exp);
        chk({tag, "_mis"}, 32'(mis), 32'(ref_mis(sz, a)));
    endtask

    task automatic store(input int i, input logic [1:0] sz, input logic [11:0] a,
                         input logic [31:0] wd);
        logic [31:0] rd; logic mis; int lat, bc;
        access(i, 1'b1, sz, 1'b0, a, wd, rd, mis, lat, bc);
        chk("store_rdata", rd, 32'h0);
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic mis, mis_e, w, u;
        logic [1:0] sz;
        logic [11:0] a;
        logic [31:0] wd;
        int lat, bc, nack, ack_at;

        rst_n = '0; req = '0; we = '0; unsigned_ld = '0; size = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", 32'(ack[i]), 32'h0);
            chk("rst_busy", 32'(busy[i]), 32'h0);
            chk("rst_misalign", 32'(misalign[i]), 32'h0);
            chk("rst_rdata", rdata[i], 32'h0);
        end
        rst_n = '1;

        // WAIT_CYC=1 directed accesses
        access(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, rd, mis, lat, bc);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_busy_cycles", 32'(bc), 32'd2);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_mis", 32'(mis), 32'h0);
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack[0]), 32'h0);
        load_chk(0, "lw_010", 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);

        store(0, 2'b00, 12'h013, 32'h0000_0080);
        load_chk(0, "lb_013", 2'b00, 1'b0, 12'h013, 32'hFFFF_FF80);
        load_chk(0, "lbu_013", 2'b00, 1'b1, 12'h013, 32'h0000_0080);
        load_chk(0, "lw_010_b", 2'b10, 1'b0, 12'h010, 32'h80AD_BEEF);

        store(0, 2'b01, 12'h022, 32'h0000_1234);
        load_chk(0, "lh_022", 2'b01, 1'b0, 12'h022, 32'h0000_1234);
        store(0, 2'b01, 12'h020, 32'h0000_F00D);
        load_chk(0, "lw_020", 2'b10, 1'b0, 12'h020, 32'h1234_F00D);
        load_chk(0, "lh_020", 2'b01, 1'b0, 12'h020, 32'hFFFF_F00D);
        load_chk(0, "lhu_020", 2'b01, 1'b1, 12'h020, 32'h0000_F00D);

        access(0, 1'b0, 2'b10, 1'b0, 12'h011, 32'h0, rd, mis, lat, bc);
        chk("mis_lat", 32'(lat), 32'd0);
        chk("mis_flag", 32'(mis), 32'h1);
        chk("mis_rdata", rd, 32'h0);
        chk("mis_busy", 32'(bc), 32'd0);
        access(0, 1'b1, 2'b10, 1'b0, 12'h012, 32'h1111_1111, rd, mis, lat, bc);
        chk("mis_store_flag", 32'(mis), 32'h1);
        load_chk(0, "lw_010_c", 2'b10, 1'b0, 12'h010, 32'h80AD_BEEF);
        access(0, 1'b0, 2'b11, 1'b0, 12'h010, 32'h0, rd, mis, lat, bc);
        chk("size11_mis", 32'(mis), 32'h1);
        chk("size11_rdata", rd, 32'h0);

        // WAIT_CYC=0 back-to-back stores with req held high
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; addr[1] = 12'h040;
        wdata[1] = 32'hA000_0000;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_ack", 32'(ack[1]), 32'(c % 2 == 1));
            if (c % 2 == 0) begin
                addr[1] = 12'(12'h040 + 4 * (c / 2 + 1));
                wdata[1] = 32'hA000_0000 + 32'(c / 2 + 1);
            end
            if (c == 7) req[1] = 1'b0;
        end
        for (int k = 0; k < 4; k++)
            load_chk(1, "b2b_data", 2'b10, 1'b0, 12'(12'h040 + 4 * k), 32'hA000_0000 + 32'(k));

        // WAIT_CYC=3: req pulses while busy must not produce extra acks
        store(2, 2'b10, 12'h030, 32'h0BAD_F00D);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; size[2] = 2'b10; addr[2] = 12'h030;
        nack = 0; ack_at = -1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[2]) begin
                nack++;
                if (ack_at < 0) begin ack_at = c; rd = rdata[2]; end
            end
            req[2] = busy[2];
        end
        req[2] = 1'b0;
        chk("busy_req_acks", 32'(nack), 32'd1);
        chk("busy_req_ack_edge", 32'(ack_at), 32'd4);
        chk("busy_req_rdata", rd, 32'h0BAD_F00D);

        // Reset one cycle after accepting a store
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; addr[2] = 12'h030;
        wdata[2] = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        chk("rstmid_busy_before", 32'(busy[2]), 32'h1);
        rst_n[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy", 32'(busy[2]), 32'h0);
        chk("rstmid_ack", 32'(ack[2]), 32'h0);
        chk("rstmid_rdata", rdata[2], 32'h0);
        rst_n[2] = 1'b1;
        nack = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[2]) nack++;
        end
        chk("rstmid_no_ack", 32'(nack), 32'd0);
        load_chk(2, "rstmid_mem", 2'b10, 1'b0, 12'h030, 32'h0BAD_F00D);

        // Random accesses on WAIT_CYC=0 over a pre-filled region
        for (int j = 0; j < 16; j++) begin
            wd = $urandom;
            a = 12'(12'h100 + 4 * j);
            store(1, 2'b10, a, wd);
            ref_store(a, 2'b10, wd);
        end
        for (int n = 0; n < 60; n++) begin
            a = 12'(12'h100 + $urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            wd = $urandom;
            mis_e = ref_mis(sz, a);
            exp_rd = (mis_e || w) ? 32'h0 : ref_load(a, sz, u);
            access(1, w, sz, u, a, wd, rd, mis, lat, bc);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_mis", 32'(mis), 32'(mis_e));
            chk("rnd_lat", 32'(lat), mis_e ? 32'd0 : 32'd1);
            if (w && !mis_e) ref_store(a, sz, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle MIPS data memory.
- Byte-addressed, 32-bit word storage with byte, halfword and word access, load sign/zero extension, and misalignment detection.
- Configurable wait-state FSM with req/ack handshake, so the datapath can stall on memory.
- Sits between the MEM stage and the on-chip data array.

Parameters:
- ADDR_W, 12, byte-address width; depth = 2**(ADDR_W-2) 32-bit words.
- WAIT_CYC, 1, extra wait cycles before the access is performed; 0 is legal; range 0..15.
- DATA_W, 32, data width; fixed at 32 (N from the_pkg); any other value is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  access request; sampled only while busy=0.
- we  input  1  1=store, 0=load.
- size  input  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned).
- unsigned_ld  input  1  1=zero-extend byte/half loads, 0=sign-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  output  32  load result; valid while ack=1; holds until the next ack.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  request in flight; new req ignored.
- misalign  output  1  high with ack when the access was rejected.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, ack=0, busy=0, misalign=0, rdata=0, wait counter=0. Memory contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- Acceptance edge E0: req=1 and state IDLE or DONE. Latch we, size, unsigned_ld, addr, wdata. Clear the counter.
- Aligned access: go to BUSY. busy=1 in BUSY.
- Misaligned access: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Go straight to DONE with ack=1, misalign=1, rdata=0. Memory is untouched.
- In BUSY the counter increments each edge. At the edge where counter==WAIT_CYC, the access is performed and the FSM goes to DONE.
- Timing: ack rises WAIT_CYC+1 edges after E0 and lasts exactly one cycle. With WAIT_CYC=0, accept at E0 gives ack in the cycle after E1.
- DONE: ack=1, busy=0. A req present in DONE is accepted (back-to-back, 2+WAIT_CYC cycles per access). Without req, DONE goes to IDLE.
- req while busy=1 is ignored and not queued; the requester retries after busy falls.
- Store lane mapping, little-endian, word index = addr[ADDR_W-1:2]:
  - Byte: wdata[7:0] to lane addr[1:0].
  - Half: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Unselected lanes keep their value.
- Load: rdata is registered at the access edge.
  - Byte: lane addr[1:0], extended per unsigned_ld.
  - Half: the selected half, extended per unsigned_ld.
  - Word: the whole word; unsigned_ld is ignored.
- Store completion drives rdata=0.
- Addresses span the full depth; there is no out-of-range case.
- Reset mid-operation (rst_n=0 in BUSY): return to IDLE with no ack. A store not yet performed is discarded, and memory is never partially written.
- misalign is only ever high together with ack.

Test Plan:
- WAIT_CYC=1. Store word 0xDEADBEEF @0x010 accepted at E0 -> ack in the cycle after E2, busy high for 2 cycles. Then load word @0x010 -> rdata=0xDEADBEEF.
- Store byte 0x80 @0x013, then load byte @0x013: signed -> 0xFFFFFF80; unsigned -> 0x00000080. Load word @0x010 -> 0x80ADBEEF.
- Store half 0x1234 @0x022, load half @0x022 signed -> 0x00001234. Store half 0xF00D @0x020, load word @0x020 -> 0x1234F00D.
- Load word @0x011 -> ack=1 and misalign=1 the cycle after E0, rdata=0. A following load word @0x010 is unchanged. size=11 also gives misalign.
- WAIT_CYC=0, back-to-back reqs held high for 4 accesses -> ack every 2nd cycle. Extra req pulses during busy produce no extra ack.
- Store word 0x55555555 @0x030, with rst_n=0 one cycle after acceptance (WAIT_CYC=3) -> no ack, busy=0. Later load word @0x030 -> previous contents.
